// File: rtl/ram_ctrl_pkg.sv
// Shared types for the single-port RAM controller: FSM state encoding
// and the depth helper used to size the array and the clear counter.
package ram_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_SCAN  = 2'd2
    } state_e;

    function automatic int unsigned ram_depth(input int unsigned aw);
        return 32'd1 << aw;
    endfunction

endpackage

// File: rtl/ram_ctrl_sp_if.sv
// Access bus of ram_ctrl_sp: request/write strobes in, read data and status out.
// RAM_CTRL_SCAN_EN adds the scan request line.
interface ram_ctrl_sp_if #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 5
);

    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              clr;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;
    logic              busy;
    logic              clr_done;
    logic [ADDR_W-1:0] scan_addr;
`ifdef RAM_CTRL_SCAN_EN
    logic              scan;

    modport master (
        output req, we, addr, wdata, clr, scan,
        input  rdata, rvalid, busy, clr_done, scan_addr
    );

    modport slave (
        input  req, we, addr, wdata, clr, scan,
        output rdata, rvalid, busy, clr_done, scan_addr
    );
`else
    modport master (
        output req, we, addr, wdata, clr,
        input  rdata, rvalid, busy, clr_done, scan_addr
    );

    modport slave (
        input  req, we, addr, wdata, clr,
        output rdata, rvalid, busy, clr_done, scan_addr
    );
`endif

endinterface

// File: rtl/ram_sp.sv
// Plain synchronous single-port array, read-first, no reset on contents,
// written so synthesis maps it onto block RAM.
module ram_sp
    import ram_ctrl_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 5
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned DEPTH = ram_depth(ADDR_W);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
        rdata <= mem_q[addr];
    end

endmodule

// File: rtl/ram_ctrl_sp.sv
// Single-port RAM controller: reads/writes, FSM bulk clear and, with
// RAM_CTRL_SCAN_EN, a free-running scan read of the whole array.
module ram_ctrl_sp
    import ram_ctrl_pkg::*;
#(
    parameter int              DATA_W  = 4,
    parameter int              ADDR_W  = 5,
    parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
    input logic          clock,
    input logic          resetn,
    ram_ctrl_sp_if.slave bus
);

    localparam logic [ADDR_W-1:0] LAST_ADDR =
        ADDR_W'(ram_depth(ADDR_W) - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              rvalid_q, rvalid_d;
    logic              clr_done_q, clr_done_d;
    logic [DATA_W-1:0] hold_q, hold_d;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

`ifdef RAM_CTRL_SCAN_EN
    logic [ADDR_W-1:0] scan_addr_q, scan_addr_d;
`endif

    ram_sp #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clock (clock),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rvalid_d   = 1'b0;
        clr_done_d = 1'b0;
        hold_d     = rvalid_q ? mem_rdata : hold_q;
        mem_we     = 1'b0;
        mem_addr   = bus.addr;
        mem_wdata  = bus.wdata;
`ifdef RAM_CTRL_SCAN_EN
        scan_addr_d = scan_addr_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (bus.clr) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
`ifdef RAM_CTRL_SCAN_EN
                else if (bus.scan) begin
                    state_d = ST_SCAN;
                end
`endif
                else if (bus.req) begin
                    mem_we   = bus.we;
                    rvalid_d = !bus.we;
                end
            end
            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_addr  = cnt_q;
                mem_wdata = CLR_VAL;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == LAST_ADDR) begin
                    state_d    = ST_IDLE;
                    clr_done_d = 1'b1;
                end
            end
`ifdef RAM_CTRL_SCAN_EN
            ST_SCAN: begin
                // Dropping scan ends the sweep; the last read's
                // rvalid is already on the bus this cycle.
                if (bus.scan) begin
                    mem_addr    = scan_addr_q;
                    rvalid_d    = 1'b1;
                    scan_addr_d = scan_addr_q + 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // A reset edge must not disturb the array, even mid-clear.
        if (!resetn) begin
            mem_we = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            rvalid_q   <= 1'b0;
            clr_done_q <= 1'b0;
            hold_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rvalid_q   <= rvalid_d;
            clr_done_q <= clr_done_d;
            hold_q     <= hold_d;
        end
    end

`ifdef RAM_CTRL_SCAN_EN
    always_ff @(posedge clock) begin
        if (!resetn) begin
            scan_addr_q <= '0;
        end else begin
            scan_addr_q <= scan_addr_d;
        end
    end

    assign bus.scan_addr = scan_addr_q;
`else
    assign bus.scan_addr = '0;
`endif

    assign bus.rdata    = rvalid_q ? mem_rdata : hold_q;
    assign bus.rvalid   = rvalid_q;
    assign bus.busy     = (state_q != ST_IDLE);
    assign bus.clr_done = clr_done_q;

endmodule
